// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a CPU write to DMA_REG_ADDR stalls the core and copies
// one 256-byte page of CPU space into PPU OAM as alternating read/write cycles.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_wr,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  reg_data,
    input  logic [7:0]  mem_rd_data,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        cpu_stall,
    output logic        oam_dma,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data_in,
    output logic        dma_done,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       parity_q, parity_d;
    logic       p_q, p_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic       done_q, done_d;

    always_comb begin
        state_d     = state_q;
        parity_d    = ~parity_q;
        p_d         = p_q;
        page_d      = page_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        mem_rd      = 1'b0;
        mem_addr    = 16'h0000;
        oam_dma     = 1'b0;
        oam_addr    = 8'h00;
        oam_data_in = 8'h00;
        cpu_stall   = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                // Writes to the trigger address are only honoured here.
                if (reg_wr && (reg_addr == DMA_REG_ADDR)) begin
                    page_d  = reg_data;
                    p_d     = parity_q;
                    idx_d   = 8'h00;
                    state_d = HALT;
                end
            end
            HALT: begin
                // An odd trigger needs one extra cycle so READ lands on even parity.
                state_d = p_q ? ALIGN : READ;
            end
            ALIGN: begin
                state_d = READ;
            end
            READ: begin
                mem_rd   = 1'b1;
                mem_addr = {page_q, idx_q};
                state_d  = WRITE;
            end
            WRITE: begin
                oam_dma     = 1'b1;
                oam_addr    = idx_q;
                oam_data_in = mem_rd_data;
                if (idx_q == 8'hFF) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = READ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            parity_q <= 1'b0;
            p_q      <= 1'b0;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            p_q      <= p_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
        end
    end

    assign dma_done  = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: memory model, scoreboard of expected OAM writes and
// read addresses, and one task per scenario.
module tb_oam_dma_ctrl;

    logic        clk;
    logic        reset;
    logic        reg_wr;
    logic [15:0] reg_addr;
    logic [7:0]  reg_data;
    logic [7:0]  mem_rd_data;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        cpu_stall;
    logic        oam_dma;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data_in;
    logic        dma_done;
    logic [2:0]  state_dbg;

    int errors;
    int checks;
    int stall_cnt;
    int wr_cnt;
    logic tb_par;
    logic mon_en;

    logic [15:0] exp_q[$];
    logic [15:0] rd_q[$];

    oam_dma_ctrl #(.DMA_REG_ADDR(16'h4014)) dut (
        .clk         (clk),
        .reset       (reset),
        .reg_wr      (reg_wr),
        .reg_addr    (reg_addr),
        .reg_data    (reg_data),
        .mem_rd_data (mem_rd_data),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .cpu_stall   (cpu_stall),
        .oam_dma     (oam_dma),
        .oam_addr    (oam_addr),
        .oam_data_in (oam_data_in),
        .dma_done    (dma_done),
        .state_dbg   (state_dbg)
    );

    // clock / reference parity
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) tb_par <= 1'b0;
        else        tb_par <= ~tb_par;
    end

    // CPU-space content: page 2 holds i^5A, other pages differ
    function automatic logic [7:0] ram_fn(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02;
    endfunction

    always @(posedge clk) begin
        if (mem_rd === 1'b1) mem_rd_data <= ram_fn(mem_addr);
        else                 mem_rd_data <= 8'hEE;
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (cpu_stall === 1'b1) stall_cnt++;
            if (oam_dma === 1'b1) begin
                wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL oam_write_unexpected: addr=%02h data=%02h, required no write", oam_addr, oam_data_in);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if ({oam_addr, oam_data_in} !== e) begin
                        errors++;
                        $display("FAIL oam_write: addr/data=%04h, required %04h", {oam_addr, oam_data_in}, e);
                    end
                end
            end
            if (mem_rd === 1'b1) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_read_unexpected: addr=%04h, required no read", mem_addr);
                end else begin
                    logic [15:0] e;
                    e = rd_q.pop_front();
                    if (mem_addr !== e || tb_par !== 1'b0) begin
                        errors++;
                        $display("FAIL mem_read: addr=%04h parity=%0b, required addr=%04h parity=0", mem_addr, tb_par, e);
                    end
                end
            end
            if (cpu_stall === 1'b0) begin
                checks++;
                if ({mem_addr, oam_addr, oam_data_in, mem_rd, oam_dma} !== 34'h0) begin
                    errors++;
                    $display("FAIL idle_outputs: mem_addr=%04h oam_addr=%02h oam_data=%02h mem_rd=%0b oam_dma=%0b, required all 0",
                             mem_addr, oam_addr, oam_data_in, mem_rd, oam_dma);
                end
            end
        end
    end

    // driver tasks
    task automatic pulse_wr(input logic [15:0] addr, input logic [7:0] data);
        reg_wr   = 1'b1;
        reg_addr = addr;
        reg_data = data;
        @(posedge clk); #1;
        reg_wr   = 1'b0;
        reg_addr = 16'h0000;
        reg_data = 8'h00;
    endtask

    task automatic push_expect(input logic [7:0] page);
        for (int i = 0; i < 256; i++) begin
            logic [15:0] a;
            a = {page, i[7:0]};
            exp_q.push_back({i[7:0], ram_fn(a)});
            rd_q.push_back(a);
        end
    endtask

    task automatic start_transfer(input logic [7:0] page, input logic par);
        @(posedge clk); #1;
        if (tb_par != par) begin
            @(posedge clk); #1;
        end
        push_expect(page);
        stall_cnt = 0;
        wr_cnt    = 0;
        pulse_wr(16'h4014, page);
    endtask

    task automatic finish_transfer(input int exp_stall, input string name);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 1500 && !found; c++) begin
            @(negedge clk);
            if (dma_done === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_done_timeout: no dma_done within 1500 cycles, required one", name);
        end
        checks++;
        if (stall_cnt != exp_stall) begin
            errors++;
            $display("FAIL %s_stall_len: %0d cycles, required %0d", name, stall_cnt, exp_stall);
        end
        checks++;
        if (wr_cnt != 256) begin
            errors++;
            $display("FAIL %s_write_count: %0d, required 256", name, wr_cnt);
        end
        checks++;
        if (exp_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: writes=%0d reads=%0d pending, required 0", name, exp_q.size(), rd_q.size());
            exp_q.delete();
            rd_q.delete();
        end
        @(negedge clk);
        checks++;
        if (dma_done !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: dma_done=%0b cpu_stall=%0b after pulse, required 0 0", name, dma_done, cpu_stall);
        end
    endtask

    // scenarios
    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_addr, mem_rd, cpu_stall, oam_dma, oam_addr, oam_data_in, dma_done, state_dbg} !== 39'h0) begin
            errors++;
            $display("FAIL reset_outputs: mem_addr=%04h mem_rd=%0b stall=%0b oam_dma=%0b oam_addr=%02h data=%02h done=%0b state=%0d, required all 0",
                     mem_addr, mem_rd, cpu_stall, oam_dma, oam_addr, oam_data_in, dma_done, state_dbg);
        end
        reset  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_even;
        start_transfer(8'h02, 1'b0);
        finish_transfer(513, "even");
    endtask

    task automatic test_odd;
        start_transfer(8'h02, 1'b1);
        finish_transfer(514, "odd");
    endtask

    task automatic test_retrigger_ignored;
        start_transfer(8'h02, 1'b0);
        repeat (98) begin
            @(posedge clk); #1;
        end
        pulse_wr(16'h4014, 8'h07);
        finish_transfer(513, "retrigger");
    endtask

    task automatic test_other_addr;
        wr_cnt = 0;
        pulse_wr(16'h4013, 8'($urandom_range(0, 255)));
        pulse_wr(16'h2004, 8'($urandom_range(0, 255)));
        repeat (6) @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || state_dbg !== 3'd0 || wr_cnt != 0) begin
            errors++;
            $display("FAIL other_addr: stall=%0b state=%0d writes=%0d, required 0 0 0", cpu_stall, state_dbg, wr_cnt);
        end
    endtask

    task automatic test_reset_mid;
        bit hit;
        start_transfer(8'h02, 1'b0);
        hit = 1'b0;
        for (int c = 0; c < 400 && !hit; c++) begin
            @(negedge clk);
            if (oam_dma === 1'b1 && oam_addr === 8'h40) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid_reach: idx 40 not written within 400 cycles, required it");
        end
        // trigger presented together with reset must be dropped
        reset    = 1'b0;
        reg_wr   = 1'b1;
        reg_addr = 16'h4014;
        reg_data = 8'h05;
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || oam_dma !== 1'b0 || mem_rd !== 1'b0 || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_abort: stall=%0b oam_dma=%0b mem_rd=%0b state=%0d, required 0 0 0 0",
                     cpu_stall, oam_dma, mem_rd, state_dbg);
        end
        exp_q.delete();
        rd_q.delete();
        @(posedge clk); #1;
        reg_wr   = 1'b0;
        reg_addr = 16'h0000;
        reg_data = 8'h00;
        reset    = 1'b1;
        wr_cnt   = 0;
        repeat (5) @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || wr_cnt != 0) begin
            errors++;
            $display("FAIL reset_mid_idle: stall=%0b writes=%0d, required 0 0", cpu_stall, wr_cnt);
        end
        start_transfer(8'h03, 1'b0);
        finish_transfer(513, "after_reset");
    endtask

    task automatic test_back_to_back;
        start_transfer(8'hFF, 1'b0);
        repeat (513) begin
            @(posedge clk); #1;
        end
        push_expect(8'h02);
        reg_wr   = 1'b1;
        reg_addr = 16'h4014;
        reg_data = 8'h02;
        @(negedge clk);
        checks++;
        if (dma_done !== 1'b1 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL page_ff_done: dma_done=%0b stall=%0b, required 1 0", dma_done, cpu_stall);
        end
        checks++;
        if (stall_cnt != 513 || wr_cnt != 256 || exp_q.size() != 256) begin
            errors++;
            $display("FAIL page_ff_transfer: stall=%0d writes=%0d pending=%0d, required 513 256 256",
                     stall_cnt, wr_cnt, exp_q.size());
        end
        stall_cnt = 0;
        wr_cnt    = 0;
        @(posedge clk); #1;
        reg_wr   = 1'b0;
        reg_addr = 16'h0000;
        reg_data = 8'h00;
        finish_transfer(513, "back_to_back");
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        stall_cnt   = 0;
        wr_cnt      = 0;
        mon_en      = 1'b0;
        reset       = 1'b0;
        reg_wr      = 1'b0;
        reg_addr    = 16'h0000;
        reg_data    = 8'h00;
        test_reset();
        test_even();
        test_odd();
        test_retrigger_ignored();
        test_other_addr();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'h4014, CPU write address that triggers a transfer.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port reg_wr  input  1  CPU write strobe, one cycle per write.
REQ-005 SHALL have port reg_addr  input  16  CPU write address.
REQ-006 SHALL have port reg_data  input  8  CPU write data; source page number.
REQ-007 SHALL have port mem_rd_data  input  8  CPU-space read data, valid the cycle after mem_rd.
REQ-008 SHALL have port mem_addr  output  16  CPU-space read address.
REQ-009 SHALL have port mem_rd  output  1  CPU-space read strobe.
REQ-010 SHALL have port cpu_stall  output  1  holds the CPU core while high.
REQ-011 SHALL have port oam_dma  output  1  OAM write enable into the PPU.
REQ-012 SHALL have port oam_addr  output  8  OAM byte index.
REQ-013 SHALL have port oam_data_in  output  8  OAM write data into the PPU.
REQ-014 SHALL have port dma_done  output  1  one-cycle pulse after the last OAM write.

Function
REQ-015 SHALL keep a parity flop that toggles every clock and resets to 0 (even).
REQ-016 SHALL use the states IDLE, HALT, ALIGN, READ and WRITE.
REQ-017 SHALL treat the cycle in which reg_wr=1 and reg_addr==DMA_REG_ADDR in IDLE as the trigger, latch reg_data as page, latch trigger parity p, clear idx to 0 and go to HALT.
REQ-018 SHALL, from HALT, go to ALIGN when p=1 and to READ when p=0, so that the first READ always falls on an even-parity cycle.
REQ-019 SHALL go from ALIGN to READ.
REQ-020 SHALL, in READ, drive mem_rd=1 and mem_addr={page, idx}, then go to WRITE.
REQ-021 SHALL, in WRITE, drive oam_dma=1, oam_addr=idx and oam_data_in=mem_rd_data (combinational pass-through of the read issued in the prior cycle).
REQ-022 SHALL, in WRITE, go to READ with idx+1 when idx!=8'hFF.
REQ-023 SHALL, in WRITE with idx==8'hFF, go to IDLE and assert dma_done=1 in the following cycle only.
REQ-024 SHALL keep idx 8 bits wide; it never wraps within a transfer because the transfer terminates at 8'hFF.
REQ-025 SHALL drive cpu_stall=1 in HALT, ALIGN, READ and WRITE, and 0 in IDLE.
REQ-026 SHALL give a total stall of 513 cycles for p=0 and 514 cycles for p=1.
REQ-027 SHALL hold mem_rd=0 and oam_dma=0 outside READ and WRITE respectively; mem_addr, oam_addr and oam_data_in SHALL be 0 in IDLE.
REQ-028 SHALL ignore writes to DMA_REG_ADDR while not in IDLE; page and idx are unchanged.
REQ-029 SHALL ignore writes to any other address in every state.
REQ-030 SHALL treat a trigger in the same cycle dma_done is high as a new transfer.
REQ-031 SHALL accept page 8'hFF; mem_addr then spans 16'hFF00-16'hFFFF without overflow into other bits.

Reset
REQ-032 SHALL, when reset=0 at a clock edge, set state=IDLE, parity=0, page=0 and idx=0, and drive every output to 0 on the next cycle.
REQ-033 SHALL abandon a transfer in progress on reset with no further OAM writes; the OAM contents already written are left as is.
REQ-034 SHALL ignore any trigger presented in the same cycle as reset=0.

Verification
REQ-035 Trigger on even parity, reg_data=8'h02, RAM[16'h0200+i]=i^8'h5A -> cpu_stall high for exactly 513 cycles; 256 oam_dma pulses with oam_addr=i and oam_data_in=i^8'h5A; one dma_done pulse.
REQ-036 Same stimulus with trigger on odd parity -> cpu_stall high for 514 cycles; first mem_rd on an even-parity cycle; data identical.
REQ-037 Second write to 16'h4014 with data 8'h07 at transfer cycle 100 -> page stays 8'h02; all addresses read are 16'h02xx.
REQ-038 reset=0 when idx=8'h40 -> next cycle cpu_stall=0, oam_dma=0, state IDLE; a new trigger with 8'h03 then completes a full 256-byte transfer from 16'h0300.
REQ-039 Write to 16'h4013 and to 16'h2004 -> no stall, no mem_rd, no oam_dma.
REQ-040 Page 8'hFF -> last read address 16'hFFFF, last write oam_addr=8'hFF, dma_done follows, then back-to-back trigger accepted in the dma_done cycle.
